// File: rtl/lfsr_axi_fetch.sv
// lfsr_axi_fetch: AXI4-Lite read master that drains the LFSR peripheral.
// Each output pair is built from two reads:
//   - the address read at BASE_ADDR supplies the low PAIR_ADDR_WIDTH bits;
//   - the data read at BASE_ADDR+4 supplies the full data word.
// The pair is then offered on a valid/ready port.
//
// Ports:
//   m00_axi_aclk / m00_axi_aresetn : clock, async active-low reset
//   start, count                   : launch a run of `count` pairs (sampled in IDLE)
//   busy, done, err                : run in progress, end-of-run pulse, sticky error
//   m00_axi_ar* / m00_axi_r*       : AXI4-Lite read address / read data channels
//   pair_valid/ready/addr/data     : output pair stream
//
// Optional build macro: LFSR_FETCH_RRESP_CHECK_EN.
// When defined, a non-OKAY rresp aborts the run and sets err.
module lfsr_axi_fetch #(
    parameter int unsigned C_M00_AXI_ADDR_WIDTH = 4,
    parameter int unsigned C_M00_AXI_DATA_WIDTH = 32,
    parameter int unsigned PAIR_ADDR_WIDTH      = 10,
    parameter int unsigned BASE_ADDR            = 0,
    parameter int unsigned COUNT_WIDTH          = 16
) (
    input  logic                            m00_axi_aclk,
    input  logic                            m00_axi_aresetn,
    input  logic                            start,
    input  logic [COUNT_WIDTH-1:0]          count,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0] m00_axi_araddr,
    output logic [2:0]                      m00_axi_arprot,
    output logic                            m00_axi_arvalid,
    input  logic                            m00_axi_arready,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0] m00_axi_rdata,
    input  logic [1:0]                      m00_axi_rresp,
    input  logic                            m00_axi_rvalid,
    output logic                            m00_axi_rready,
    output logic                            pair_valid,
    input  logic                            pair_ready,
    output logic [PAIR_ADDR_WIDTH-1:0]      pair_addr,
    output logic [C_M00_AXI_DATA_WIDTH-1:0] pair_data
);

    localparam logic [C_M00_AXI_ADDR_WIDTH-1:0] ADDR_A = C_M00_AXI_ADDR_WIDTH'(BASE_ADDR);
    localparam logic [C_M00_AXI_ADDR_WIDTH-1:0] ADDR_D = C_M00_AXI_ADDR_WIDTH'(BASE_ADDR + 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR_A,
        S_R_A,
        S_AR_D,
        S_R_D,
        S_OUT
    } state_e;

    state_e                            state_q;
    logic [COUNT_WIDTH-1:0]            remaining_q;
    logic [COUNT_WIDTH-1:0]            remaining_d;
    logic                              busy_q;
    logic                              done_q;
    logic                              err_q;
    logic [C_M00_AXI_ADDR_WIDTH-1:0]   araddr_q;
    logic                              arvalid_q;
    logic                              rready_q;
    logic                              pair_valid_q;
    logic [PAIR_ADDR_WIDTH-1:0]        pair_addr_q;
    logic [C_M00_AXI_DATA_WIDTH-1:0]   pair_data_q;
    logic                              rresp_bad_c;

    // Remaining count after the pair currently in OUT is accepted.
    assign remaining_d = remaining_q - COUNT_WIDTH'(1);

`ifdef LFSR_FETCH_RRESP_CHECK_EN
    assign rresp_bad_c = (m00_axi_rresp != 2'b00);
`else
    // rresp is ignored in this build.
    logic unused_rresp_c;
    assign unused_rresp_c = ^m00_axi_rresp;
    assign rresp_bad_c    = 1'b0;
`endif

    // Run-control FSM; all outputs are registered here.
    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            state_q      <= S_IDLE;
            remaining_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            pair_valid_q <= 1'b0;
            pair_addr_q  <= '0;
            pair_data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        err_q <= 1'b0;
                        if (count == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            remaining_q <= count;
                            busy_q      <= 1'b1;
                            arvalid_q   <= 1'b1;
                            araddr_q    <= ADDR_A;
                            state_q     <= S_AR_A;
                        end
                    end
                end
                S_AR_A: begin
                    if (m00_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_R_A;
                    end
                end
                S_R_A: begin
                    if (m00_axi_rvalid) begin
                        rready_q <= 1'b0;
                        if (rresp_bad_c) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            pair_addr_q <= m00_axi_rdata[PAIR_ADDR_WIDTH-1:0];
                            arvalid_q   <= 1'b1;
                            araddr_q    <= ADDR_D;
                            state_q     <= S_AR_D;
                        end
                    end
                end
                S_AR_D: begin
                    if (m00_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_R_D;
                    end
                end
                S_R_D: begin
                    if (m00_axi_rvalid) begin
                        rready_q <= 1'b0;
                        if (rresp_bad_c) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            pair_data_q  <= m00_axi_rdata;
                            pair_valid_q <= 1'b1;
                            state_q      <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (pair_ready) begin
                        pair_valid_q <= 1'b0;
                        remaining_q  <= remaining_d;
                        if (remaining_d == '0) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            arvalid_q <= 1'b1;
                            araddr_q  <= ADDR_A;
                            state_q   <= S_AR_A;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign m00_axi_araddr  = araddr_q;
    assign m00_axi_arprot  = 3'b000;
    assign m00_axi_arvalid = arvalid_q;
    assign m00_axi_rready  = rready_q;
    assign pair_valid      = pair_valid_q;
    assign pair_addr       = pair_addr_q;
    assign pair_data       = pair_data_q;

endmodule

// File: tb/tb_lfsr_axi_fetch.sv
// Directed testbench for lfsr_axi_fetch.
// A small AXI-Lite slave model is included, with programmable ready/valid
// delays and a single injectable error response.
module tb_lfsr_axi_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] count;
    logic        busy, done, err;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic        pair_valid, pair_ready;
    logic [9:0]  pair_addr;
    logic [31:0] pair_data;

    lfsr_axi_fetch dut (
        .m00_axi_aclk    (clk),
        .m00_axi_aresetn (rst_n),
        .start           (start),
        .count           (count),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .m00_axi_araddr  (araddr),
        .m00_axi_arprot  (arprot),
        .m00_axi_arvalid (arvalid),
        .m00_axi_arready (arready),
        .m00_axi_rdata   (rdata),
        .m00_axi_rresp   (rresp),
        .m00_axi_rvalid  (rvalid),
        .m00_axi_rready  (rready),
        .pair_valid      (pair_valid),
        .pair_ready      (pair_ready),
        .pair_addr       (pair_addr),
        .pair_data       (pair_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Read data served for the i-th read of the run; first four are the LFSR reference values.
    function automatic logic [31:0] rdv(input int i);
        case (i)
            0:       return 32'hFFFF_FFFF;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'hFFBF_FFF7;
            3:       return 32'hFFBF_FFF9;
            default: return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
        endcase
    endfunction

    // Slave model
    int   ar_dly = 0, r_dly = 0, err_idx = -1;
    int   s_arw, s_rw, s_idx;
    logic s_pend;

    assign arready = arvalid && (s_arw >= ar_dly);
    assign rvalid  = s_pend && (s_rw >= r_dly);
    assign rdata   = rdv(s_idx);
    assign rresp   = (rvalid && s_idx == err_idx) ? 2'b10 : 2'b00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_pend <= 1'b0; s_arw <= 0; s_rw <= 0; s_idx <= 0;
        end else begin
            if (arvalid && arready) begin
                s_arw <= 0; s_pend <= 1'b1; s_rw <= 0;
            end else if (arvalid) begin
                s_arw <= s_arw + 1;
            end
            if (s_pend && !(arvalid && arready)) begin
                if (rvalid && rready) begin
                    s_pend <= 1'b0; s_idx <= s_idx + 1;
                end else begin
                    s_rw <= s_rw + 1;
                end
            end
        end
    end

    // Protocol monitor and event recorder
    logic [3:0]  ar_q[$];
    logic [41:0] pv_q[$];
    int          pc_q[$];
    int          done_n = 0, done_cyc = 0, st_cyc = 0, viol = 0;
    logic        prev_arv = 1'b0, prev_arr = 1'b0;
    logic [3:0]  prev_addr = 4'd0;

    always @(posedge clk) begin
        if (rst_n) begin
            if (arvalid && arready) ar_q.push_back(araddr);
            if (pair_valid && pair_ready) begin
                pv_q.push_back({pair_addr, pair_data});
                pc_q.push_back(cyc);
            end
            if (done) begin done_n = done_n + 1; done_cyc = cyc; end
            if (start && !busy) st_cyc = cyc;
            if (prev_arv && !prev_arr && (!arvalid || araddr != prev_addr)) viol = viol + 1;
            if (rready && (arvalid || !s_pend)) viol = viol + 1;
            if (arvalid && s_pend) viol = viol + 1;
            if (pair_valid && (arvalid || rready)) viol = viol + 1;
            if (arprot != 3'b000) viol = viol + 1;
            prev_arv = arvalid; prev_arr = arready; prev_addr = araddr;
        end else begin
            prev_arv = 1'b0; prev_arr = 1'b0; prev_addr = 4'd0;
        end
    end

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [15:0] n);
        @(negedge clk);
        count = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0; count = 16'($urandom);
    endtask

    task automatic wait_done(input int target, input string tag);
        int k = 0;
        while (done_n < target && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(done_n >= target), 64'd1);
    endtask

    initial begin
        int ri, p0, a0, d0, bad, k;
        logic [9:0]  ea;
        logic [31:0] w0, w1, ed;

        rst_n = 1'b0; start = 1'b0; count = '0; pair_ready = 1'b0;
        ri = 0;

        // Reset hold with random inputs
        repeat (3) begin
            @(negedge clk);
            start = 1'($urandom); count = 16'($urandom); pair_ready = 1'($urandom);
        end
        chk("rst_busy",    64'(busy), 64'd0);
        chk("rst_done",    64'(done), 64'd0);
        chk("rst_err",     64'(err), 64'd0);
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        chk("rst_rready",  64'(rready), 64'd0);
        chk("rst_araddr",  64'(araddr), 64'd0);
        chk("rst_arprot",  64'(arprot), 64'd0);
        chk("rst_pvalid",  64'(pair_valid), 64'd0);
        chk("rst_paddr",   64'(pair_addr), 64'd0);
        chk("rst_pdata",   64'(pair_data), 64'd0);
        start = 1'b0; pair_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // count = 0: done next cycle, no bus traffic
        go(16'd0);
        chk("cnt0_done",    64'(done), 64'd1);
        chk("cnt0_busy",    64'(busy), 64'd0);
        chk("cnt0_arvalid", 64'(arvalid), 64'd0);
        @(negedge clk);
        chk("cnt0_done_low", 64'(done), 64'd0);
        chk("cnt0_no_ar",    64'(ar_q.size()), 64'd0);

        // Reference sequence, count = 2
        pair_ready = 1'b1;
        p0 = pv_q.size(); a0 = ar_q.size(); d0 = done_n;
        go(16'd2);
        chk("int_busy",    64'(busy), 64'd1);
        chk("int_arvalid", 64'(arvalid), 64'd1);
        chk("int_araddr",  64'(araddr), 64'd0);
        wait_done(d0 + 1, "int_done_timeout");
        chk("int_npairs", 64'(pv_q.size() - p0), 64'd2);
        chk("int_pair0",  64'(pv_q[p0]),     {22'd0, 10'h3FF, 32'hFFFF_FFFF});
        chk("int_pair1",  64'(pv_q[p0 + 1]), {22'd0, 10'h3F7, 32'hFFBF_FFF9});
        chk("int_arseq",  64'({ar_q[a0], ar_q[a0 + 1], ar_q[a0 + 2], ar_q[a0 + 3]}), 64'h0404);
        chk("int_done_lat", 64'(done_cyc - pc_q[p0 + 1]), 64'd1);
        chk("int_busy_end", 64'(busy), 64'd0);
        ri = 4;

        // Zero-wait latency and throughput, count = 3
        p0 = pv_q.size(); d0 = done_n;
        go(16'd3);
        wait_done(d0 + 1, "zw_done_timeout");
        chk("zw_npairs",   64'(pv_q.size() - p0), 64'd3);
        chk("zw_first",    64'(pc_q[p0] - st_cyc), 64'd5);
        chk("zw_space1",   64'(pc_q[p0 + 1] - pc_q[p0]), 64'd5);
        chk("zw_space2",   64'(pc_q[p0 + 2] - pc_q[p0 + 1]), 64'd5);
        chk("zw_done_lat", 64'(done_cyc - pc_q[p0 + 2]), 64'd1);
        for (int i = 0; i < 3; i++) begin
            w0 = rdv(ri + 2 * i); w1 = rdv(ri + 2 * i + 1);
            chk($sformatf("zw_pair%0d", i), 64'(pv_q[p0 + i]), 64'({w0[9:0], w1}));
        end
        ri = ri + 6;

        // Backpressure on the output port
        pair_ready = 1'b0;
        p0 = pv_q.size(); d0 = done_n;
        go(16'd2);
        k = 0;
        while (!pair_valid && k < 100) begin @(negedge clk); k++; end
        chk("bp_pv_timeout", 64'(pair_valid), 64'd1);
        w0 = rdv(ri); ed = rdv(ri + 1); ea = w0[9:0];
        chk("bp_addr", 64'(pair_addr), 64'(ea));
        chk("bp_data", 64'(pair_data), 64'(ed));
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!pair_valid || pair_addr !== ea || pair_data !== ed || arvalid) bad++;
        end
        chk("bp_hold", 64'(bad), 64'd0);
        pair_ready = 1'b1;
        @(negedge clk);
        chk("bp_next_ar", 64'(arvalid), 64'd1);
        chk("bp_pv_low",  64'(pair_valid), 64'd0);
        wait_done(d0 + 1, "bp_done_timeout");
        chk("bp_npairs", 64'(pv_q.size() - p0), 64'd2);
        ri = ri + 4;

        // Slave stalls plus an ignored mid-run start
        ar_dly = 3; r_dly = 4;
        p0 = pv_q.size(); d0 = done_n;
        go(16'd2);
        repeat (6) @(negedge clk);
        count = 16'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("st_busy_kept", 64'(busy), 64'd1);
        wait_done(d0 + 1, "st_done_timeout");
        repeat (20) @(negedge clk);
        chk("st_one_done", 64'(done_n - d0), 64'd1);
        chk("st_npairs",   64'(pv_q.size() - p0), 64'd2);
        for (int i = 0; i < 2; i++) begin
            w0 = rdv(ri + 2 * i); w1 = rdv(ri + 2 * i + 1);
            chk($sformatf("st_pair%0d", i), 64'(pv_q[p0 + i]), 64'({w0[9:0], w1}));
        end
        chk("st_protocol", 64'(viol), 64'd0);
        ri = ri + 4;
        ar_dly = 0; r_dly = 0;

        // Error response on the data read of the first pair, count = 4
        err_idx = ri + 1;
        p0 = pv_q.size(); d0 = done_n;
        go(16'd4);
        wait_done(d0 + 1, "er_done_timeout");
        @(negedge clk);
`ifdef LFSR_FETCH_RRESP_CHECK_EN
        chk("er_err",    64'(err), 64'd1);
        chk("er_npairs", 64'(pv_q.size() - p0), 64'd0);
        chk("er_busy",   64'(busy), 64'd0);
        ri = ri + 2;
        err_idx = -1;
        d0 = done_n; p0 = pv_q.size();
        go(16'd1);
        chk("er_err_cleared", 64'(err), 64'd0);
        wait_done(d0 + 1, "er2_done_timeout");
        chk("er2_npairs", 64'(pv_q.size() - p0), 64'd1);
        ri = ri + 2;
`else
        chk("er_err",    64'(err), 64'd0);
        chk("er_npairs", 64'(pv_q.size() - p0), 64'd4);
        w0 = rdv(ri); w1 = rdv(ri + 1);
        chk("er_pair0",  64'(pv_q[p0]), 64'({w0[9:0], w1}));
        ri = ri + 8;
        err_idx = -1;
`endif

        chk("protocol_final", 64'(viol), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
